// File: rtl/cr_bmu_sbus_arb_if.sv
// Bundle of the instruction-side, data-side and shared system-bus signals around the
// two-requester system-bus arbiter. The arbiter uses the slave view; the environment uses the master view.
interface cr_bmu_sbus_arb_if #(
   parameter int DATA_W = 32
);
   logic              ibus_req;
   logic [31:0]       ibus_addr;
   logic [3:0]        ibus_prot;
   logic              ibus_grnt;
   logic              ibus_data_vld;
   logic [DATA_W-1:0] ibus_data;
   logic              ibus_acc_err;
   logic              ibus_trans_cmplt;

   logic              dbus_req;
   logic [31:0]       dbus_addr;
   logic              dbus_write;
   logic [1:0]        dbus_size;
   logic [3:0]        dbus_prot;
   logic [DATA_W-1:0] dbus_wdata;
   logic              dbus_grnt;
   logic              dbus_data_vld;
   logic [DATA_W-1:0] dbus_data;
   logic              dbus_acc_err;
   logic              dbus_trans_cmplt;

   logic              biu_req;
   logic [31:0]       biu_addr;
   logic              biu_write;
   logic [1:0]        biu_size;
   logic [3:0]        biu_prot;
   logic [DATA_W-1:0] biu_wdata;
   logic              biu_src;
   logic              biu_grnt;
   logic              biu_data_vld;
   logic [DATA_W-1:0] biu_data;
   logic              biu_acc_err;
   logic              biu_trans_cmplt;

   logic              arb_busy;

   modport slave (
      input  ibus_req, ibus_addr, ibus_prot,
      output ibus_grnt, ibus_data_vld, ibus_data, ibus_acc_err, ibus_trans_cmplt,
      input  dbus_req, dbus_addr, dbus_write, dbus_size, dbus_prot, dbus_wdata,
      output dbus_grnt, dbus_data_vld, dbus_data, dbus_acc_err, dbus_trans_cmplt,
      output biu_req, biu_addr, biu_write, biu_size, biu_prot, biu_wdata, biu_src,
      input  biu_grnt, biu_data_vld, biu_data, biu_acc_err, biu_trans_cmplt,
      output arb_busy
   );

   modport master (
      output ibus_req, ibus_addr, ibus_prot,
      input  ibus_grnt, ibus_data_vld, ibus_data, ibus_acc_err, ibus_trans_cmplt,
      output dbus_req, dbus_addr, dbus_write, dbus_size, dbus_prot, dbus_wdata,
      input  dbus_grnt, dbus_data_vld, dbus_data, dbus_acc_err, dbus_trans_cmplt,
      input  biu_req, biu_addr, biu_write, biu_size, biu_prot, biu_wdata, biu_src,
      output biu_grnt, biu_data_vld, biu_data, biu_acc_err, biu_trans_cmplt,
      input  arb_busy
   );
endinterface

// File: rtl/cr_bmu_sbus_arb.sv
// Round-robin arbiter sharing one system-bus port between instruction and data requesters,
// with at most one outstanding transaction and responses steered back to the owner.
module cr_bmu_sbus_arb (
   input  logic               cpuclk,
   input  logic               cpurst,
   cr_bmu_sbus_arb_if.slave   bus
);
   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] OWN_I = 2'b01;
   localparam logic [1:0] OWN_D = 2'b10;

   logic [1:0] state;
   logic       last_d;
   logic       idle;
   logic       any_req;
   logic       win_d;
   logic       grant;
   logic       own_i;
   logic       own_d;

   always_comb begin
      idle    = (state == IDLE);
      any_req = bus.ibus_req | bus.dbus_req;
      // dbus wins alone, or on a tie when ibus was granted most recently
      win_d   = bus.dbus_req & (~bus.ibus_req | ~last_d);
      grant   = ~cpurst & idle & any_req & bus.biu_grnt;
      // a zero-wait grant makes the winner the owner within the same cycle
      own_i   = ~cpurst & ((state == OWN_I) | (grant & ~win_d));
      own_d   = ~cpurst & ((state == OWN_D) | (grant &  win_d));
   end

   assign bus.biu_req   = ~cpurst & idle & any_req;
   assign bus.biu_src   = win_d;
   assign bus.biu_addr  = win_d ? bus.dbus_addr  : bus.ibus_addr;
   assign bus.biu_prot  = win_d ? bus.dbus_prot  : bus.ibus_prot;
   assign bus.biu_write = win_d & bus.dbus_write;
   assign bus.biu_size  = win_d ? bus.dbus_size  : 2'b10;
   assign bus.biu_wdata = win_d ? bus.dbus_wdata : '0;

   assign bus.ibus_grnt = grant & ~win_d;
   assign bus.dbus_grnt = grant &  win_d;

   assign bus.ibus_data_vld    = own_i & bus.biu_data_vld;
   assign bus.ibus_data        = (own_i & bus.biu_data_vld) ? bus.biu_data : '0;
   assign bus.ibus_acc_err     = own_i & bus.biu_acc_err;
   assign bus.ibus_trans_cmplt = own_i & bus.biu_trans_cmplt;

   assign bus.dbus_data_vld    = own_d & bus.biu_data_vld;
   assign bus.dbus_data        = (own_d & bus.biu_data_vld) ? bus.biu_data : '0;
   assign bus.dbus_acc_err     = own_d & bus.biu_acc_err;
   assign bus.dbus_trans_cmplt = own_d & bus.biu_trans_cmplt;

   assign bus.arb_busy = (state != IDLE);

   always_ff @(posedge cpuclk) begin
      if (cpurst) begin
         state  <= IDLE;
         last_d <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  last_d <= win_d;
                  if (!bus.biu_trans_cmplt)
                     state <= win_d ? OWN_D : OWN_I;
               end
            end
            OWN_I, OWN_D: begin
               if (bus.biu_trans_cmplt)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
